byang_inv_host: RTL

// - Byte-stream host front end for the modular inverter. Shifts in a 256-bit operand MSB-byte-first.
// - Issues one request on the inverter's valid/ready input, then waits for its valid/ready result.
// - Streams the 256-bit result back out MSB-byte-first, with out_last on the final byte.
// - Sits between the chip byte I/O (UART/SPI byte layer) and the inverter core; one transaction in flight.

---
 rtl/byang_inv_host.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/byang_inv_host.sv
// byang_inv_host: byte-stream host front end for the modular inverter.
// Collects an OP_BITS operand MSB-byte-first, hands it to the inverter over a
// valid/ready request, captures the valid/ready response and streams the result
// back MSB-byte-first with out_last on the final byte. One transaction in flight.
// Optional feature macro: BYANG_HOST_ZERO_CHECK_EN -- an all-zero operand skips
// the inverter, returns zero and raises err_zero.
module byang_inv_host #(
    parameter int OP_BITS = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_data,
    output logic               out_last,
    output logic               req_valid,
    input  logic               req_ready,
    output logic [OP_BITS-1:0] req_a,
    input  logic               rsp_valid,
    output logic               rsp_ready,
    input  logic [OP_BITS-1:0] rsp_result,
    output logic               busy,
    output logic               err_zero
);

    localparam int OP_BYTES = OP_BITS / 8;
    localparam int CNT_W    = (OP_BYTES > 1) ? $clog2(OP_BYTES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_RX   = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_TX   = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OP_BITS-1:0] opnd_q, opnd_d;
    logic [OP_BITS-1:0] res_q, res_d;
`ifdef BYANG_HOST_ZERO_CHECK_EN
    logic               err_zero_q, err_zero_d;
`endif

    // Next-state and datapath update for the RX -> REQ -> WAIT -> TX cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opnd_d  = opnd_q;
        res_d   = res_q;
`ifdef BYANG_HOST_ZERO_CHECK_EN
        err_zero_d = err_zero_q;
`endif
        case (state_q)
            ST_RX: begin
                if (in_valid) begin
                    opnd_d = {opnd_q[OP_BITS-9:0], in_data};
`ifdef BYANG_HOST_ZERO_CHECK_EN
                    err_zero_d = 1'b0;
`endif
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = CNT_ZERO;
`ifdef BYANG_HOST_ZERO_CHECK_EN
                        // A zero operand has no inverse: answer zero locally.
                        if (opnd_d == '0) begin
                            state_d    = ST_TX;
                            res_d      = '0;
                            err_zero_d = 1'b1;
                        end else begin
                            state_d = ST_REQ;
                        end
`else
                        state_d = ST_REQ;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = ST_RX;
                end
            end
            ST_REQ: begin
                if (req_ready) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (rsp_valid) begin
                    res_d   = rsp_result;
                    state_d = ST_TX;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_TX: begin
                if (out_ready) begin
                    res_d = res_q << 8;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = CNT_ZERO;
                        state_d = ST_RX;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = ST_TX;
                end
            end
            default: begin
                state_d = ST_RX;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State registers with synchronous reset; reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RX;
            cnt_q   <= CNT_ZERO;
            opnd_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            res_q   <= res_d;
        end
    end

`ifdef BYANG_HOST_ZERO_CHECK_EN
    // Zero-operand flag: set at end of RX, cleared by the next accepted byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_zero_q <= 1'b0;
        end else begin
            err_zero_q <= err_zero_d;
        end
    end

    assign err_zero = err_zero_q;
`else
    assign err_zero = 1'b0;
`endif

    // Handshake outputs decode directly from registered state.
    assign in_ready  = (state_q == ST_RX);
    assign req_valid = (state_q == ST_REQ);
    assign req_a     = opnd_q;
    assign rsp_ready = (state_q == ST_WAIT);
    assign out_valid = (state_q == ST_TX);
    assign out_data  = res_q[OP_BITS-1 -: 8];
    assign out_last  = (state_q == ST_TX) && (cnt_q == CNT_LAST);
    assign busy      = !((state_q == ST_RX) && (cnt_q == CNT_ZERO));

endmodule
